// File: rtl/xmit_top.sv
// Transmit frame buffer: two priority queues with store-and-forward admission,
// drained onto a 4-bit PHY at half the system clock rate.
module xmit_top #(
  parameter int unsigned DATA_DEPTH  = 2048,
  parameter int unsigned CTRL_DEPTH  = 16,
  parameter int unsigned IFG_NIBBLES = 24
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        f_rec_frame_valid,
  input  logic [23:0] f_ctrl_in,
  input  logic        f_hi_priority,
  input  logic        f_rec_data_valid,
  input  logic [7:0]  f_data_in,
  output logic [3:0]  phy_data_out,
  output logic        phy_tx_en,
  output logic        m_discard_en
);
  localparam int unsigned AW  = $clog2(DATA_DEPTH);
  localparam int unsigned CW  = $clog2(CTRL_DEPTH);
  localparam int unsigned PW  = AW + 1;
  localparam int unsigned CPW = CW + 1;

  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_IFG} tx_state_t;

  logic [7:0]    data_mem [2*DATA_DEPTH];
  logic [11:0]   desc_mem [2*CTRL_DEPTH];
  logic [AW:0]   data_wp  [2];
  logic [AW:0]   data_rp  [2];
  logic [CW:0]   desc_wp  [2];
  logic [CW:0]   desc_rp  [2];

  logic          rx_active, rx_q;
  logic [11:0]   rx_len, rx_cnt;
  logic          tick_tgl, tick;
  tx_state_t     tx_state;
  logic          tx_q;
  logic [11:0]   tx_len;
  logic [12:0]   nib_cnt;
  logic [15:0]   ifg_cnt;

  logic          ctrl_unused;
  logic [11:0]   new_len, cur_len, cur_cnt;
  logic [AW:0]   used_new;
  logic          new_full, accept, cur_active, cur_q, wr_en, wr_last;
  logic [AW-1:0] wr_off, rd_off;
  logic          hi_avail, lo_avail, pick_q, sel_q;
  logic [12:0]   nib_idx;
  logic [7:0]    rd_byte;
  logic [3:0]    rd_nib;
  logic [11:0]   next_len;

  assign ctrl_unused = ^f_ctrl_in[23:12];
  assign tick        = ~tick_tgl;

  // Writes land at committed pointer + offset; the pointer only advances once
  // a frame completes, so dropping a partial frame needs no explicit rollback.
  always_comb begin
    new_len    = f_ctrl_in[11:0];
    used_new   = data_wp[f_hi_priority] - data_rp[f_hi_priority];
    new_full   = (desc_wp[f_hi_priority] ^ desc_rp[f_hi_priority]) == {1'b1, {CW{1'b0}}};
    accept     = (new_len != '0) && !new_full &&
                 (32'(used_new) + 32'(new_len) <= DATA_DEPTH);
    cur_active = f_rec_frame_valid ? accept        : rx_active;
    cur_q      = f_rec_frame_valid ? f_hi_priority : rx_q;
    cur_len    = f_rec_frame_valid ? new_len       : rx_len;
    cur_cnt    = f_rec_frame_valid ? '0            : rx_cnt;
    wr_en      = cur_active && f_rec_data_valid;
    wr_last    = wr_en && (cur_cnt + 12'd1 == cur_len);
    wr_off     = data_wp[cur_q][AW-1:0] + AW'(cur_cnt);
  end

  always_comb begin
    hi_avail = desc_wp[1] != desc_rp[1];
    lo_avail = desc_wp[0] != desc_rp[0];
    pick_q   = hi_avail;
    sel_q    = (tx_state == TX_IDLE) ? pick_q : tx_q;
    nib_idx  = (tx_state == TX_IDLE) ? '0 : nib_cnt;
    rd_off   = data_rp[sel_q][AW-1:0] + AW'(nib_idx[12:1]);
    rd_byte  = data_mem[{sel_q, rd_off}];
    rd_nib   = nib_idx[0] ? rd_byte[7:4] : rd_byte[3:0];
    next_len = desc_mem[{pick_q, desc_rp[pick_q][CW-1:0]}];
  end

  always_ff @(posedge clk_sys) begin
    if (wr_en)   data_mem[{cur_q, wr_off}] <= f_data_in;
    if (wr_last) desc_mem[{cur_q, desc_wp[cur_q][CW-1:0]}] <= cur_len;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rx_active    <= 1'b0;
      rx_q         <= 1'b0;
      rx_len       <= '0;
      rx_cnt       <= '0;
      m_discard_en <= 1'b0;
      for (int unsigned q = 0; q < 2; q++) begin
        data_wp[q] <= '0;
        desc_wp[q] <= '0;
      end
    end else begin
      rx_active    <= cur_active && !wr_last;
      rx_q         <= cur_q;
      rx_len       <= cur_len;
      rx_cnt       <= wr_en ? cur_cnt + 12'd1 : cur_cnt;
      m_discard_en <= f_rec_frame_valid && (rx_active || !accept);
      if (wr_last) begin
        data_wp[cur_q] <= data_wp[cur_q] + PW'(cur_len);
        desc_wp[cur_q] <= desc_wp[cur_q] + CPW'(1);
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      tick_tgl     <= 1'b0;
      tx_state     <= TX_IDLE;
      tx_q         <= 1'b0;
      tx_len       <= '0;
      nib_cnt      <= '0;
      ifg_cnt      <= '0;
      phy_data_out <= '0;
      phy_tx_en    <= 1'b0;
      for (int unsigned q = 0; q < 2; q++) begin
        data_rp[q] <= '0;
        desc_rp[q] <= '0;
      end
    end else begin
      tick_tgl <= ~tick_tgl;
      if (tick) begin
        case (tx_state)
          TX_IDLE: begin
            if (hi_avail || lo_avail) begin
              tx_q         <= pick_q;
              tx_len       <= next_len;
              phy_data_out <= rd_nib;
              phy_tx_en    <= 1'b1;
              nib_cnt      <= 13'd1;
              tx_state     <= TX_SEND;
            end
          end
          TX_SEND: begin
            // The tick ending the frame is the first of the inter-frame gap.
            if (nib_cnt == {tx_len, 1'b0}) begin
              phy_data_out  <= '0;
              phy_tx_en     <= 1'b0;
              desc_rp[tx_q] <= desc_rp[tx_q] + CPW'(1);
              data_rp[tx_q] <= data_rp[tx_q] + PW'(tx_len);
              ifg_cnt       <= 16'd1;
              tx_state      <= TX_IFG;
            end else begin
              phy_data_out <= rd_nib;
              nib_cnt      <= nib_cnt + 13'd1;
            end
          end
          TX_IFG: begin
            ifg_cnt <= ifg_cnt + 16'd1;
            if (ifg_cnt >= 16'(IFG_NIBBLES - 1)) tx_state <= TX_IDLE;
          end
          default: tx_state <= TX_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_xmit_top.sv
// Directed bench for xmit_top: a PHY monitor captures frames; the main sequence
// checks content, spacing, priority, discards and reset behaviour.
module tb_xmit_top;
  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        f_rec_frame_valid = 1'b0;
  logic [23:0] f_ctrl_in = '0;
  logic        f_hi_priority = 1'b0;
  logic        f_rec_data_valid = 1'b0;
  logic [7:0]  f_data_in = '0;
  logic [3:0]  phy_data_out;
  logic        phy_tx_en;
  logic        m_discard_en;

  always #5 clk_sys = ~clk_sys;

  xmit_top dut (
    .clk_sys(clk_sys), .reset(reset),
    .f_rec_frame_valid(f_rec_frame_valid), .f_ctrl_in(f_ctrl_in),
    .f_hi_priority(f_hi_priority), .f_rec_data_valid(f_rec_data_valid),
    .f_data_in(f_data_in), .phy_data_out(phy_data_out),
    .phy_tx_en(phy_tx_en), .m_discard_en(m_discard_en)
  );

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  logic [3:0] nibs [8192];
  int fr_start [128];
  int fr_cyc   [128];
  int fr_gap   [128];
  int fr_t0    [128];
  int nfr = 0, nnib = 0, en_cyc = 0, low_cyc = 0;
  int disc_cnt = 0, disc_dbl = 0, idle_nz = 0;
  logic prev_en = 1'b0, prev_disc = 1'b0;

  // Each nibble is held for two clocks; capture on the first clock of each pair.
  initial forever begin
    @(negedge clk_sys);
    if (phy_tx_en) begin
      if (!prev_en && nfr < 128) begin
        fr_start[nfr] = nnib; fr_gap[nfr] = low_cyc; fr_t0[nfr] = cyc; en_cyc = 0;
      end
      if (en_cyc % 2 == 0 && nnib < 8192) begin nibs[nnib] = phy_data_out; nnib++; end
      en_cyc++;
    end else begin
      if (prev_en) begin
        if (nfr < 128) fr_cyc[nfr] = en_cyc;
        nfr++; low_cyc = 0;
      end
      low_cyc++;
      if (phy_data_out != 4'h0) idle_nz++;
    end
    if (m_discard_en) begin disc_cnt++; if (prev_disc) disc_dbl++; end
    prev_en = phy_tx_en; prev_disc = m_discard_en;
  end

  task automatic chk(input string tag, input int obs, input int expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] byte_at(input int i, input int len, input logic [7:0] tag);
    return (i < 4 || i >= len - 4) ? tag : 8'hFF;
  endfunction

  function automatic int frame_errs(input int f, input int len, input logic [7:0] tag);
    int e;
    logic [7:0] b;
    logic [3:0] x;
    e = 0;
    if (f >= 128 || f >= nfr) return 1;
    if (fr_cyc[f] != 4 * len) e++;
    for (int n = 0; n < 2 * len; n++) begin
      b = byte_at(n / 2, len, tag);
      x = (n % 2 == 1) ? b[7:4] : b[3:0];
      if (fr_start[f] + n >= 8192) e++;
      else if (nibs[fr_start[f] + n] !== x) e++;
    end
    return e;
  endfunction

  task automatic send_frame(input logic hi, input int len, input int nbytes, input logic [7:0] tag);
    for (int i = 0; i < nbytes; i++) begin
      f_rec_frame_valid = (i == 0);
      f_ctrl_in         = (i == 0) ? {12'h040, 12'(len)} : 24'h0;
      f_hi_priority     = hi;
      f_rec_data_valid  = 1'b1;
      f_data_in         = byte_at(i, len, tag);
      @(posedge clk_sys); #1;
    end
    f_rec_frame_valid = 1'b0;
    f_rec_data_valid  = 1'b0;
    f_data_in         = '0;
  endtask

  task automatic wait_frames(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (nfr < n && k < budget) begin @(posedge clk_sys); k++; end
    chk(tag, (nfr >= n) ? 1 : 0, 1);
  endtask

  initial begin
    int t_last, d, d0, f0, dd, errs, k;

    repeat (3) @(posedge clk_sys); #1;
    chk("reset_tx_en", int'(phy_tx_en), 0);
    chk("reset_data", int'(phy_data_out), 0);
    chk("reset_discard", int'(m_discard_en), 0);
    reset = 1'b0;
    repeat (4) @(posedge clk_sys); #1;

    // Single 64-byte low-priority frame
    send_frame(1'b0, 64, 64, 8'h00);
    t_last = cyc;
    wait_frames(1, 1000, "single_done");
    d = fr_t0[0] - t_last;
    chk("single_latency_1to2", (d >= 1 && d <= 2) ? 1 : 0, 1);
    chk("single_cycles", fr_cyc[0], 256);
    chk("single_content", frame_errs(0, 64, 8'h00), 0);
    chk("single_no_discard", disc_cnt, 0);
    repeat (60) @(posedge clk_sys); #1;

    // Two back-to-back frames
    send_frame(1'b0, 64, 64, 8'h00);
    send_frame(1'b0, 64, 64, 8'h00);
    wait_frames(3, 2000, "b2b_done");
    chk("b2b_f1_content", frame_errs(1, 64, 8'h00), 0);
    chk("b2b_f2_content", frame_errs(2, 64, 8'h00), 0);
    chk("b2b_gap_cycles", fr_gap[2], 48);
    repeat (60) @(posedge clk_sys); #1;

    // Priority: low then high queued while a frame transmits
    send_frame(1'b0, 16, 16, 8'h11);
    send_frame(1'b0, 16, 16, 8'h22);
    send_frame(1'b1, 16, 16, 8'h33);
    wait_frames(6, 2000, "prio_done");
    chk("prio_first", frame_errs(3, 16, 8'h11), 0);
    chk("prio_high_next", frame_errs(4, 16, 8'h33), 0);
    chk("prio_low_last", frame_errs(5, 16, 8'h22), 0);
    chk("prio_gap", fr_gap[5], 48);
    repeat (60) @(posedge clk_sys); #1;

    // Truncation, zero-length and one-byte frames
    d0 = disc_cnt;
    send_frame(1'b0, 64, 10, 8'h44);
    send_frame(1'b0, 32, 32, 8'h55);
    wait_frames(7, 2000, "trunc_done");
    chk("trunc_one_discard", disc_cnt - d0, 1);
    chk("trunc_new_frame", frame_errs(6, 32, 8'h55), 0);
    repeat (60) @(posedge clk_sys); #1;
    send_frame(1'b0, 0, 4, 8'h66);
    send_frame(1'b1, 1, 1, 8'h77);
    wait_frames(8, 500, "len1_done");
    chk("len0_discarded", disc_cnt - d0, 2);
    chk("len1_content", frame_errs(7, 1, 8'h77), 0);
    repeat (100) @(posedge clk_sys); #1;
    chk("no_extra_frames", nfr, 8);

    // Overflow with sustained high-priority input
    d0 = disc_cnt; f0 = nfr;
    for (int i = 0; i < 64; i++) send_frame(1'b1, 64, 64, 8'h00);
    repeat (2) @(posedge clk_sys); #1;
    dd = disc_cnt - d0;
    chk("ovf_discards_in_range", (dd >= 25 && dd <= 45) ? 1 : 0, 1);
    wait_frames(f0 + 64 - dd, 30000, "ovf_drain");
    repeat (400) @(posedge clk_sys); #1;
    chk("ovf_sent_equals_accepted", nfr - f0, 64 - dd);
    errs = 0;
    for (int f = f0; f < nfr; f++) errs += frame_errs(f, 64, 8'h00);
    chk("ovf_all_frames_intact", errs, 0);
    chk("discard_never_double", disc_dbl, 0);

    // Reset mid-transmission with another frame queued
    send_frame(1'b0, 64, 64, 8'h00);
    send_frame(1'b0, 64, 64, 8'h00);
    k = 0;
    while (!phy_tx_en && k < 200) begin @(posedge clk_sys); #1; k++; end
    repeat (20) @(posedge clk_sys); #1;
    chk("rst_tx_active_before", int'(phy_tx_en), 1);
    reset = 1'b1;
    #1;
    chk("rst_tx_en_immediate", int'(phy_tx_en), 0);
    chk("rst_data_immediate", int'(phy_data_out), 0);
    repeat (3) @(posedge clk_sys); #1;
    reset = 1'b0;
    f0 = nfr;
    repeat (1500) @(posedge clk_sys); #1;
    chk("rst_nothing_after", nfr, f0);
    chk("rst_tx_en_idle", int'(phy_tx_en), 0);
    send_frame(1'b0, 8, 8, 8'h5A);
    wait_frames(f0 + 1, 500, "rst_new_frame_done");
    chk("rst_new_frame_content", frame_errs(f0, 8, 8'h5A), 0);
    repeat (60) @(posedge clk_sys); #1;
    chk("idle_data_zero", idle_nz, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
